// File: rtl/control_unit_if.sv
// control_unit_if: bus between the controller and the instruction memory,
// register file, ALU and data memory.
`default_nettype none

interface control_unit_if #(
  parameter int PC_W = 8
);
  logic            instr_req;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic [15:0]     instr_in;
  logic [3:0]      alu_op;
  logic            alu_enable;
  logic            alu_zero;
  logic [3:0]      rd_sel;
  logic [3:0]      rs1_sel;
  logic [3:0]      rs2_sel;
  logic            rf_we;
  logic            wb_sel;
  logic            mem_req;
  logic            mem_we;
  logic            mem_ready;
  logic            halted;

  modport master (
    output instr_req, pc, alu_op, alu_enable, rd_sel, rs1_sel, rs2_sel,
           rf_we, wb_sel, mem_req, mem_we, halted,
    input  instr_valid, instr_in, alu_zero, mem_ready
  );

  modport slave (
    input  instr_req, pc, alu_op, alu_enable, rd_sel, rs1_sel, rs2_sel,
           rf_we, wb_sel, mem_req, mem_we, halted,
    output instr_valid, instr_in, alu_zero, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit: multi-cycle fetch/decode/execute FSM for a 16-bit datapath.
// Optional retire counter enabled by macro CU_RETIRE_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module control_unit #(
  parameter int PC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  control_unit_if.master    bus
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SEQ   = 4'hA;
  localparam logic [3:0] OP_LOAD  = 4'hB;
  localparam logic [3:0] OP_STORE = 4'hC;
  localparam logic [3:0] OP_BEQ   = 4'hD;
  localparam logic [3:0] OP_JMP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam int         JW       = (PC_W > 12) ? 12 : PC_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0]      opcode;
  logic            is_alu;
  logic [3:0]      ex_op;
  logic [PC_W-1:0] pc_inc, pc_br, pc_jmp;

  logic            instr_req_c, alu_enable_c, rf_we_c, wb_sel_c;
  logic            mem_req_c, mem_we_c, halted_c, sel_en_c;
  logic [3:0]      alu_op_c;

  assign opcode = ir_q[15:12];
  assign is_alu = (opcode != OP_NOP) && (opcode <= OP_SEQ);
  // LOAD/STORE reuse ADD for the address, BEQ compares via SEQ.
  assign ex_op  = is_alu ? opcode : ((opcode == OP_BEQ) ? OP_SEQ : OP_ADD);
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_br  = pc_inc + PC_W'($signed(ir_q[11:8]));
  assign pc_jmp = PC_W'(ir_q[JW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    instr_req_c  = 1'b0;
    alu_enable_c = 1'b0;
    alu_op_c     = 4'h0;
    rf_we_c      = 1'b0;
    wb_sel_c     = 1'b0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    halted_c     = 1'b0;
    sel_en_c     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        instr_req_c = 1'b1;
        if (bus.instr_valid) begin
          ir_d    = bus.instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        sel_en_c = 1'b1;
        case (opcode)
          OP_NOP: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = pc_jmp;
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        sel_en_c     = 1'b1;
        alu_enable_c = 1'b1;
        alu_op_c     = ex_op;
        if (is_alu) begin
          state_d = S_WRITEBACK;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_d = S_MEM;
        end else begin
          // SEQ yields 1 on equality, so a clear zero flag means taken.
          pc_d    = bus.alu_zero ? pc_inc : pc_br;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        sel_en_c     = 1'b1;
        alu_enable_c = 1'b1;
        alu_op_c     = OP_ADD;
        mem_req_c    = 1'b1;
        mem_we_c     = (opcode == OP_STORE);
        if (bus.mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        sel_en_c     = 1'b1;
        rf_we_c      = 1'b1;
        alu_enable_c = 1'b1;
        alu_op_c     = ex_op;
        wb_sel_c     = (opcode == OP_LOAD);
        pc_d         = pc_inc;
        state_d      = S_FETCH;
      end
      S_HALT: halted_c = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.instr_req  = instr_req_c;
  assign bus.pc         = pc_q;
  assign bus.alu_op     = alu_op_c;
  assign bus.alu_enable = alu_enable_c;
  assign bus.rd_sel     = sel_en_c ? ir_q[11:8] : 4'h0;
  assign bus.rs1_sel    = sel_en_c ? ir_q[7:4]  : 4'h0;
  assign bus.rs2_sel    = sel_en_c ? ir_q[3:0]  : 4'h0;
  assign bus.rf_we      = rf_we_c;
  assign bus.wb_sel     = wb_sel_c;
  assign bus.mem_req    = mem_req_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.halted     = halted_c;

`ifdef CU_RETIRE_CNT_EN
  logic [15:0] retire_q;
  logic        retire_w;

  assign retire_w = (state_d == S_FETCH) &&
                    ((state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                     (state_q == S_MEM) || (state_q == S_WRITEBACK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= 16'h0000;
    end else if (retire_w) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign retire_cnt = retire_q;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// tb_control_unit: directed instruction stream with a queue-based scoreboard
// checking fetch addresses, latency, ALU usage, memory and writeback events.
`default_nettype none

module tb_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_unit_if #(.PC_W(8)) bus ();

`ifdef CU_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  control_unit #(.PC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CU_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  typedef struct { logic [7:0] pc; int lat; int alu; logic [3:0] op; } fexp_t;
  typedef struct { logic [3:0] rd; logic wb; logic [3:0] op; } wexp_t;
  typedef struct { logic we; logic [11:0] sel; int cycles; } mexp_t;
  typedef struct packed {
    logic [15:0] instr; logic zero; logic [3:0] mdly;
    logic [7:0] npc; logic [3:0] lat; logic [3:0] alu; logic [3:0] op;
  } vec_t;

  fexp_t q_fetch[$];
  wexp_t q_wb[$];
  mexp_t q_mem[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_req, prev_we, op_bad;
  logic [3:0] op_seen;
  int         lat_cnt, alu_cnt, mem_run;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0; prev_we = 1'b0; op_bad = 1'b0; op_seen = 4'h0;
      lat_cnt = 0; alu_cnt = 0; mem_run = 0;
    end else begin
      lat_cnt++;
      if (bus.alu_enable) begin
        if (alu_cnt > 0 && bus.alu_op != op_seen) op_bad = 1'b1;
        op_seen = bus.alu_op;
        alu_cnt++;
      end
      if (bus.mem_req) begin
        mem_run++;
        if (bus.mem_ready) begin
          if (q_mem.size() == 0) chk("unexpected_mem", q_mem.size(), 1);
          else begin
            mexp_t m;
            m = q_mem.pop_front();
            chk("mem_we", bus.mem_we, m.we);
            chk("mem_sels", {bus.rd_sel, bus.rs1_sel, bus.rs2_sel}, m.sel);
            chk("mem_cycles", mem_run, m.cycles);
          end
          mem_run = 0;
        end
      end
      if (bus.rf_we) begin
        chk("rf_we_single_pulse", prev_we, 1'b0);
        if (q_wb.size() == 0) chk("unexpected_rf_we", q_wb.size(), 1);
        else begin
          wexp_t w;
          w = q_wb.pop_front();
          chk("wb_rd_sel", bus.rd_sel, w.rd);
          chk("wb_sel", bus.wb_sel, w.wb);
          chk("wb_alu_op", bus.alu_op, w.op);
          chk("wb_alu_enable", bus.alu_enable, 1'b1);
        end
      end
      prev_we = bus.rf_we;
      if (bus.instr_req && !prev_req) begin
        if (q_fetch.size() == 0) chk("unexpected_fetch", q_fetch.size(), 1);
        else begin
          fexp_t f;
          f = q_fetch.pop_front();
          chk("fetch_pc", bus.pc, f.pc);
          if (f.lat != 0) begin
            chk("latency", lat_cnt, f.lat);
            chk("alu_cycles", alu_cnt, f.alu);
            if (f.alu > 0) begin
              chk("alu_op_stable", op_bad, 1'b0);
              chk("alu_op", op_seen, f.op);
            end
          end
        end
        lat_cnt = 0; alu_cnt = 0; op_bad = 1'b0;
      end
      prev_req = bus.instr_req;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_fetch(input logic [15:0] instr, input logic zero);
    int n = 0;
    while (!bus.instr_req && n < 50) begin step(); n++; end
    chk("fetch_wait_bound", bus.instr_req, 1'b1);
    bus.instr_valid = 1'b1;
    bus.instr_in    = instr;
    bus.alu_zero    = zero;
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic serve_mem(input int dly);
    int n = 0;
    while (!bus.mem_req && n < 50) begin step(); n++; end
    chk("mem_wait_bound", bus.mem_req, 1'b1);
    repeat (dly) step();
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
  endtask

  task automatic run_instr(input vec_t v);
    fexp_t f; wexp_t w; mexp_t m;
    logic [3:0] opc;
    opc = v.instr[15:12];
    f.pc = v.npc; f.lat = int'(v.lat); f.alu = int'(v.alu); f.op = v.op;
    q_fetch.push_back(f);
    if (opc >= 4'h1 && opc <= 4'hB) begin
      w.rd = v.instr[11:8]; w.wb = (opc == 4'hB); w.op = (opc == 4'hB) ? 4'h1 : opc;
      q_wb.push_back(w);
    end
    if (opc == 4'hB || opc == 4'hC) begin
      m.we = (opc == 4'hC); m.sel = v.instr[11:0]; m.cycles = int'(v.mdly) + 1;
      q_mem.push_back(m);
    end
    issue_fetch(v.instr, v.zero);
    if (opc == 4'hB || opc == 4'hC) serve_mem(int'(v.mdly));
  endtask

  vec_t vecs [14];
  vec_t nops [3];
  fexp_t f0;

  initial begin
    //          instr     zero  mdly  next pc  lat   alu   op
    vecs = '{'{16'h1123, 1'b0, 4'd0, 8'h01, 4'd4, 4'd2, 4'h1},
             '{16'hB412, 1'b0, 4'd3, 8'h02, 4'd8, 4'd6, 4'h1},
             '{16'hC512, 1'b0, 4'd0, 8'h03, 4'd4, 4'd2, 4'h1},
             '{16'h2345, 1'b0, 4'd0, 8'h04, 4'd4, 4'd2, 4'h2},
             '{16'h0000, 1'b0, 4'd0, 8'h05, 4'd2, 4'd0, 4'h0},
             '{16'hD312, 1'b0, 4'd0, 8'h09, 4'd3, 4'd1, 4'hA},
             '{16'hE005, 1'b0, 4'd0, 8'h05, 4'd2, 4'd0, 4'h0},
             '{16'hD312, 1'b1, 4'd0, 8'h06, 4'd3, 4'd1, 4'hA},
             '{16'hE002, 1'b0, 4'd0, 8'h02, 4'd2, 4'd0, 4'h0},
             '{16'hD812, 1'b0, 4'd0, 8'hFB, 4'd3, 4'd1, 4'hA},
             '{16'hE0FF, 1'b0, 4'd0, 8'hFF, 4'd2, 4'd0, 4'h0},
             '{16'h0000, 1'b0, 4'd0, 8'h00, 4'd2, 4'd0, 4'h0},
             '{16'hE0AB, 1'b0, 4'd0, 8'hAB, 4'd2, 4'd0, 4'h0},
             '{16'h5678, 1'b0, 4'd0, 8'hAC, 4'd4, 4'd2, 4'h5}};
    nops = '{'{16'h0000, 1'b0, 4'd0, 8'h01, 4'd2, 4'd0, 4'h0},
             '{16'h0000, 1'b0, 4'd0, 8'h02, 4'd2, 4'd0, 4'h0},
             '{16'h0000, 1'b0, 4'd0, 8'h03, 4'd2, 4'd0, 4'h0}};
    f0.pc = 8'h00; f0.lat = 0; f0.alu = 0; f0.op = 4'h0;

    bus.instr_valid = 1'b0; bus.instr_in = 16'h0000;
    bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) step();
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_instr_req", bus.instr_req, 1'b0);
    chk("rst_outputs", {bus.alu_enable, bus.rf_we, bus.mem_req, bus.halted, bus.alu_op}, 8'h00);

    q_fetch.push_back(f0);
    rst_n = 1'b1;
    chk("idle_instr_req", bus.instr_req, 1'b0);
    step();
    chk("fetch_cycle1_instr_req", bus.instr_req, 1'b1);

    for (int i = 0; i < 14; i++) run_instr(vecs[i]);

    issue_fetch(16'hF000, 1'b0);
    step();
    bus.instr_valid = 1'b1;
    bus.instr_in    = 16'h1123;
    for (int i = 0; i < 4; i++) begin
      chk("halt_halted", bus.halted, 1'b1);
      chk("halt_quiet", {bus.instr_req, bus.alu_enable, bus.rf_we, bus.mem_req}, 4'h0);
      step();
    end
    bus.instr_valid = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_pc", bus.pc, 8'h00);
    chk("halt_rst_halted", bus.halted, 1'b0);
    step();
    q_fetch.push_back(f0);
    rst_n = 1'b1;

    // Store interrupted by reset while waiting on memory.
    issue_fetch(16'hC512, 1'b0);
    begin
      int n = 0;
      while (!bus.mem_req && n < 50) begin step(); n++; end
      chk("store_mem_req_seen", bus.mem_req, 1'b1);
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", bus.mem_req, 1'b0);
    chk("abort_rf_we", bus.rf_we, 1'b0);
    chk("abort_pc", bus.pc, 8'h00);
`ifdef CU_RETIRE_CNT_EN
    chk("retire_after_rst", retire_cnt, 16'd0);
`endif
    step();
    chk("abort_quiet", {bus.mem_req, bus.rf_we, bus.alu_enable}, 3'b000);
    q_fetch.push_back(f0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) run_instr(nops[i]);
    step();
    step();
`ifdef CU_RETIRE_CNT_EN
    chk("retire_after_3_nops", retire_cnt, 16'd3);
`endif
    chk("fetch_queue_drained", q_fetch.size(), 0);
    chk("wb_queue_drained", q_wb.size(), 0);
    chk("mem_queue_drained", q_mem.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle FSM controller that fetches and decodes 16-bit instructions and drives the 16-bit ALU's operation interface: alu_op, alu_enable and the returned zero flag. It also sequences register-file selects and write-enables, data-memory requests and the program counter. It sits between instruction memory, the register file, the ALU and data memory.

Parameters:
PC_W, 8, program counter width; the PC wraps modulo 2^PC_W.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_req  out  1  instruction fetch request
pc  out  PC_W  fetch address, equal to the current PC
instr_valid  in  1  instr_in is valid this cycle
instr_in  in  16  fetched instruction
alu_op  out  4  ALU operation code
alu_enable  out  1  ALU enable
alu_zero  in  1  ALU zero flag
rd_sel  out  4  destination register select = IR[11:8]
rs1_sel  out  4  ALU operand a register select = IR[7:4]
rs2_sel  out  4  ALU operand b register select = IR[3:0]
rf_we  out  1  register-file write enable, one-cycle pulse
wb_sel  out  1  writeback source: 0 = ALU result, 1 = memory read data
mem_req  out  1  data memory request; the address is the ALU result
mem_we  out  1  1 = store, 0 = load; valid while mem_req is high
mem_ready  in  1  data memory access complete
halted  out  1  high in HALT state

Behaviour:
- Reset is asynchronous and active-low. On reset: state = IDLE, PC = 0, IR = 0. All outputs are 0 while in IDLE.
- Moore outputs: every output is decoded combinationally from state and IR. Only pc comes from the PC register.
- Instruction format: IR[15:12] = opcode.
  - 0000 NOP.
  - 0001–1010 ALU ops; alu_op = opcode (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, SLT, SEQ).
  - 1011 LOAD rd <= M[rs1+rs2].
  - 1100 STORE M[rs1+rs2] <= rd.
  - 1101 BEQ: if R[rs1]==R[rs2], PC <= PC+1+sext(IR[11:8]).
  - 1110 JMP: PC <= IR[PC_W-1:0]; if PC_W > 12, zero-extend.
  - 1111 HALT.
- IDLE: always go to FETCH on the next cycle.
- FETCH: instr_req=1. Hold until instr_valid; on the instr_valid cycle, latch IR <= instr_in and go to DECODE. pc stays stable the whole time.
- DECODE: selects driven from IR, 1 cycle.
  - NOP: PC+1, go to FETCH.
  - JMP: load PC, go to FETCH.
  - HALT: go to HALT.
  - All others: go to EXECUTE.
- EXECUTE: alu_enable=1.
  - alu_op = opcode for ALU ops; 0001 for LOAD/STORE (address add); 1010 for BEQ.
  - ALU ops: go to WRITEBACK.
  - LOAD/STORE: go to MEM.
  - BEQ: taken when alu_zero==0 (SEQ result is 1). Taken: PC <= PC+1+sext(off). Not taken: PC+1. Then go to FETCH.
- MEM: alu_enable=1, alu_op=0001, mem_req=1, mem_we=(opcode==1100). Hold until mem_ready.
  - On the mem_ready cycle, LOAD goes to WRITEBACK.
  - STORE: PC+1, go to FETCH.
- WRITEBACK: rf_we=1 for exactly one cycle. alu_enable stays 1 with the same alu_op so the result is stable. wb_sel=1 for LOAD. PC+1, go to FETCH.
- HALT: halted=1, all other outputs 0. Only reset exits this state.
- Latency with zero-wait memories, from FETCH entry to the next FETCH entry:
  - NOP/JMP: 2 cycles.
  - BEQ: 3 cycles.
  - ALU op and STORE: 4 cycles.
  - LOAD: 5 cycles.
- PC arithmetic is modulo 2^PC_W. The branch offset is sign-extended 4-bit (−8..+7) and is relative to PC+1. Wrap 0xFF+1 -> 0x00 with PC_W=8.
- instr_valid outside FETCH and mem_ready outside MEM are ignored.
- Reset mid-operation (any state) returns immediately to IDLE with PC = 0. No rf_we or mem_req pulse may complete after reset asserts.

Optional Feature:
Macro CU_RETIRE_CNT_EN.
- When defined: adds output port retire_cnt (16 bits).
  - Reset value 0.
  - Increments by 1 on each instruction leaving the pipeline: transition into FETCH from DECODE, EXECUTE, MEM or WRITEBACK.
  - Wraps 0xFFFF -> 0. HALT is not counted.
- When undefined: the port and counter are absent, with identical behaviour otherwise.

Test Plan:
- Reset, then instr_valid held high with 0x1123 (ADD r1,r2,r3) -> instr_req high from cycle 1. DECODE/EXECUTE/WRITEBACK follow; alu_op=0001, alu_enable=1; rf_we is a single pulse with rd_sel=1, wb_sel=0; pc becomes 1.
- LOAD 0xB412 with mem_ready delayed 3 cycles -> mem_req=1, mem_we=0, alu_op=0001 for 4 MEM cycles. Then WRITEBACK with wb_sel=1, rd_sel=4.
- BEQ 0xD312 at pc=5: alu_zero=0 -> pc=9 (5+1+3). Repeat with alu_zero=1 -> pc=6. Offset 0x8 at pc=2 -> pc=0xFB (wrap).
- JMP 0xE0AB -> pc=0xAB after DECODE; no alu_enable, no rf_we, no mem_req.
- HALT 0xF000 -> halted=1 permanently, instr_req=0 despite instr_valid. rst_n low -> pc=0; release -> FETCH.
- rst_n asserted asynchronously mid-MEM of STORE -> mem_req drops immediately, no rf_we. With CU_RETIRE_CNT_EN, retire_cnt=0; after 3 NOPs, retire_cnt=3.
